// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared states, distance-word layout and saturation limits (NEG_CYCLE_DETECT_EN adds CHECK)
package bf_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INIT,
        S_FETCH,
        S_WAIT_E,
        S_READ_D,
        S_WAIT_D,
        S_RELAX,
        S_PASS_END,
`ifdef NEG_CYCLE_DETECT_EN
        S_CHECK,
`endif
        S_DONE
    } state_t;

    // Distance word is {inf, dist, pred}, pred in the low bits.
    function automatic int inf_bit(input int node_w, input int dist_w);
        return node_w + dist_w;
    endfunction

    function automatic int dist_lsb(input int node_w);
        return node_w;
    endfunction

    function automatic int pred_lsb();
        return 0;
    endfunction

    function automatic int dist_max(input int dist_w);
        return (1 << (dist_w - 1)) - 1;
    endfunction

    function automatic int dist_min(input int dist_w);
        return -(1 << (dist_w - 1));
    endfunction

endpackage

// File: rtl/bellman_ford_engine_if.sv
// rtl/bellman_ford_engine_if.sv - control handshake plus edge/distance memory ports
interface bellman_ford_engine_if #(
    parameter int NODE_W  = 8,
    parameter int DIST_W  = 8,
    parameter int EDGE_AW = 13
);
    logic                          start;
    logic [NODE_W-1:0]             src_node;
    logic [NODE_W:0]               num_nodes;
    logic [EDGE_AW:0]              num_edges;
    logic                          busy;
    logic                          done;
    logic                          neg_cycle;
    logic [NODE_W:0]               passes_used;
    logic [EDGE_AW-1:0]            em_addr;
    logic [2*NODE_W+DIST_W-1:0]    em_rdata;
    logic [NODE_W-1:0]             dm_raddr1;
    logic [DIST_W+NODE_W:0]        dm_rdata1;
    logic [NODE_W-1:0]             dm_raddr2;
    logic [DIST_W+NODE_W:0]        dm_rdata2;
    logic [NODE_W-1:0]             dm_waddr;
    logic [DIST_W+NODE_W:0]        dm_wdata;
    logic                          dm_we;

    modport master (
        input  start, src_node, num_nodes, num_edges, em_rdata, dm_rdata1, dm_rdata2,
        output busy, done, neg_cycle, passes_used, em_addr, dm_raddr1, dm_raddr2,
               dm_waddr, dm_wdata, dm_we
    );

    modport slave (
        output start, src_node, num_nodes, num_edges, em_rdata, dm_rdata1, dm_rdata2,
        input  busy, done, neg_cycle, passes_used, em_addr, dm_raddr1, dm_raddr2,
               dm_waddr, dm_wdata, dm_we
    );
endinterface

// File: rtl/bf_sat_add.sv
// rtl/bf_sat_add.sv - signed saturating add of dist+weight and compare against current dist
module bf_sat_add
    import bf_pkg::*;
#(
    parameter int DIST_W = 8
) (
    input  logic signed [DIST_W-1:0] a_i,
    input  logic signed [DIST_W-1:0] b_i,
    input  logic signed [DIST_W-1:0] cmp_i,
    output logic signed [DIST_W-1:0] sum_o,
    output logic                     lt_o
);
    localparam logic signed [DIST_W-1:0] MAX_V = DIST_W'(dist_max(DIST_W));
    localparam logic signed [DIST_W-1:0] MIN_V = DIST_W'(dist_min(DIST_W));

    logic [DIST_W:0] raw;

    // One extra bit catches overflow; disagreeing top bits mean clamp toward the true sign.
    always_comb begin
        raw = {a_i[DIST_W-1], a_i} + {b_i[DIST_W-1], b_i};
        if (raw[DIST_W] != raw[DIST_W-1]) begin
            sum_o = raw[DIST_W] ? MIN_V : MAX_V;
        end else begin
            sum_o = raw[DIST_W-1:0];
        end
        lt_o = sum_o < cmp_i;
    end
endmodule

// File: rtl/bellman_ford_engine.sv
// rtl/bellman_ford_engine.sv - edge-list Bellman-Ford engine; NEG_CYCLE_DETECT_EN adds a negative-cycle check pass
module bellman_ford_engine
    import bf_pkg::*;
#(
    parameter int NODE_W  = 8,
    parameter int DIST_W  = 8,
    parameter int EDGE_AW = 13
) (
    input  logic                  clock,
    input  logic                  reset,
    bellman_ford_engine_if.master bus
);
    localparam int INF_BIT  = inf_bit(NODE_W, DIST_W);
    localparam int DIST_LSB = dist_lsb(NODE_W);
    localparam int PRED_LSB = pred_lsb();
    localparam int EW       = 2 * NODE_W + DIST_W;
    localparam int DW       = 1 + DIST_W + NODE_W;
    localparam logic [NODE_W:0]  N_ONE  = (NODE_W+1)'(1);
    localparam logic [EDGE_AW:0] E_ONE  = (EDGE_AW+1)'(1);
    localparam logic [EDGE_AW:0] E_ZERO = '0;

    state_t               state_q, state_d;
    logic [NODE_W-1:0]    src_q, src_d;
    logic [NODE_W:0]      n_q, n_d;
    logic [EDGE_AW:0]     ne_q, ne_d;
    logic [NODE_W:0]      init_q, init_d;
    logic [EDGE_AW:0]     edge_q, edge_d;
    logic                 wait_q, wait_d;
    logic                 changed_q, changed_d;
    logic [NODE_W:0]      passes_q, passes_d;
`ifdef NEG_CYCLE_DETECT_EN
    logic                 check_q, check_d;
    logic                 neg_q, neg_d;
`endif
    logic [EW-1:0]        e_q;
    logic [DW-1:0]        d1_q, d2_q;

    logic [NODE_W-1:0]        e_src, e_dst;
    logic signed [DIST_W-1:0] e_w, u_dist, v_dist, cand;
    logic                     u_inf, v_inf, cand_lt, upd;

    assign e_w    = e_q[DIST_W-1:0];
    assign e_dst  = e_q[DIST_W +: NODE_W];
    assign e_src  = e_q[DIST_W+NODE_W +: NODE_W];
    assign u_inf  = d1_q[INF_BIT];
    assign v_inf  = d2_q[INF_BIT];
    assign u_dist = d1_q[DIST_LSB +: DIST_W];
    assign v_dist = d2_q[DIST_LSB +: DIST_W];
    assign upd    = !u_inf && (v_inf || cand_lt);

    bf_sat_add #(.DIST_W(DIST_W)) u_add (
        .a_i   (u_dist),
        .b_i   (e_w),
        .cmp_i (v_dist),
        .sum_o (cand),
        .lt_o  (cand_lt)
    );

    assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
    assign bus.done        = (state_q == S_DONE);
    assign bus.passes_used = passes_q;
    assign bus.em_addr     = edge_q[EDGE_AW-1:0];
    assign bus.dm_raddr1   = e_src;
    assign bus.dm_raddr2   = e_dst;
`ifdef NEG_CYCLE_DETECT_EN
    assign bus.neg_cycle   = neg_q;
`else
    assign bus.neg_cycle   = 1'b0;
`endif

    // Next-state, counters and distance-memory write port.
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        n_d       = n_q;
        ne_d      = ne_q;
        init_d    = init_q;
        edge_d    = edge_q;
        wait_d    = wait_q;
        changed_d = changed_q;
        passes_d  = passes_q;
`ifdef NEG_CYCLE_DETECT_EN
        check_d   = check_q;
        neg_d     = neg_q;
`endif
        bus.dm_we    = 1'b0;
        bus.dm_waddr = '0;
        bus.dm_wdata = '0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d   = S_INIT;
                    src_d     = bus.src_node;
                    n_d       = bus.num_nodes;
                    ne_d      = bus.num_edges;
                    init_d    = '0;
                    edge_d    = '0;
                    wait_d    = 1'b0;
                    changed_d = 1'b0;
                    passes_d  = '0;
`ifdef NEG_CYCLE_DETECT_EN
                    check_d   = 1'b0;
                    neg_d     = 1'b0;
`endif
                end
            end
            S_INIT: begin
                if (init_q < n_q) begin
                    bus.dm_we    = 1'b1;
                    bus.dm_waddr = init_q[NODE_W-1:0];
                    bus.dm_wdata = {init_q != {1'b0, src_q}, {DIST_W{1'b0}}, init_q[NODE_W-1:0]};
                end
                init_d = init_q + N_ONE;
                if (init_q + N_ONE >= n_q) begin
                    // Nothing to relax: trivial graph or a source outside the node range.
                    if (n_q <= N_ONE || ne_q == E_ZERO || {1'b0, src_q} >= n_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
            S_FETCH: state_d = S_WAIT_E;
            S_WAIT_E: begin
                wait_d = !wait_q;
                if (wait_q) state_d = S_READ_D;
            end
            S_READ_D: state_d = S_WAIT_D;
            S_WAIT_D: begin
                wait_d = !wait_q;
                if (wait_q) state_d = S_RELAX;
            end
            S_RELAX: begin
                if (upd) begin
`ifdef NEG_CYCLE_DETECT_EN
                    if (check_q) begin
                        neg_d = 1'b1;
                    end else begin
                        bus.dm_we    = 1'b1;
                        bus.dm_waddr = e_dst;
                        bus.dm_wdata = {1'b0, cand, e_src};
                        changed_d    = 1'b1;
                    end
`else
                    bus.dm_we    = 1'b1;
                    bus.dm_waddr = e_dst;
                    bus.dm_wdata = {1'b0, cand, e_src};
                    changed_d    = 1'b1;
`endif
                end
                if (edge_q == ne_q - E_ONE) begin
                    state_d = S_PASS_END;
                end else begin
                    edge_d  = edge_q + E_ONE;
                    state_d = S_FETCH;
                end
            end
            S_PASS_END: begin
                // Only passes that improved something are counted; the confirming pass is not.
                edge_d    = '0;
                changed_d = 1'b0;
`ifdef NEG_CYCLE_DETECT_EN
                if (check_q) begin
                    state_d = S_DONE;
                end else
`endif
                if (!changed_q) begin
                    state_d = S_DONE;
                end else begin
                    passes_d = passes_q + N_ONE;
                    if (passes_q + N_ONE == n_q - N_ONE) begin
`ifdef NEG_CYCLE_DETECT_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
`ifdef NEG_CYCLE_DETECT_EN
            S_CHECK: begin
                check_d = 1'b1;
                edge_d  = '0;
                state_d = S_FETCH;
            end
`endif
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            n_q       <= '0;
            ne_q      <= '0;
            init_q    <= '0;
            edge_q    <= '0;
            wait_q    <= 1'b0;
            changed_q <= 1'b0;
            passes_q  <= '0;
`ifdef NEG_CYCLE_DETECT_EN
            check_q   <= 1'b0;
            neg_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            n_q       <= n_d;
            ne_q      <= ne_d;
            init_q    <= init_d;
            edge_q    <= edge_d;
            wait_q    <= wait_d;
            changed_q <= changed_d;
            passes_q  <= passes_d;
`ifdef NEG_CYCLE_DETECT_EN
            check_q   <= check_d;
            neg_q     <= neg_d;
`endif
        end
    end

    // Boundary flops on memory read data, loaded only while waiting on that memory.
    always_ff @(posedge clock) begin
        if (reset) begin
            e_q  <= '0;
            d1_q <= '0;
            d2_q <= '0;
        end else begin
            if (state_q == S_WAIT_E) e_q <= bus.em_rdata;
            if (state_q == S_WAIT_D) begin
                d1_q <= bus.dm_rdata1;
                d2_q <= bus.dm_rdata2;
            end
        end
    end
endmodule

// File: tb/tb_bellman_ford_engine.sv
// tb/tb_bellman_ford_engine.sv - directed scoreboard bench for bellman_ford_engine
module tb_bellman_ford_engine;
    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bellman_ford_engine_if #(.NODE_W(8), .DIST_W(8), .EDGE_AW(13)) bus ();
    bellman_ford_engine #(.NODE_W(8), .DIST_W(8), .EDGE_AW(13)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [23:0] em [0:15];
    logic [16:0] dm [0:255];

    always @(posedge clock) begin
        bus.em_rdata  <= em[bus.em_addr[3:0]];
        bus.dm_rdata1 <= dm[bus.dm_raddr1];
        bus.dm_rdata2 <= dm[bus.dm_raddr2];
        if (bus.dm_we) dm[bus.dm_waddr] <= bus.dm_wdata;
    end

    typedef struct packed {
        logic [8:0]       passes;
        logic             neg;
        logic [3:0]       nn;
        logic [7:0][16:0] w;
    } exp_t;

    exp_t sb [$];
    exp_t ex;
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [16:0] wd(input logic inf, input logic [7:0] d, input logic [7:0] p);
        return {inf, d, p};
    endfunction

    function automatic logic [23:0] ed(input logic [7:0] s, input logic [7:0] d, input logic [7:0] w);
        return {s, d, w};
    endfunction

    task automatic launch(input logic [7:0] src, input logic [8:0] n, input logic [13:0] e);
        @(negedge clock);
        bus.src_node  = src;
        bus.num_nodes = n;
        bus.num_edges = e;
        bus.start     = 1'b1;
        @(negedge clock);
        bus.start     = 1'b0;
        chk("busy_after_start", bus.busy, 1);
    endtask

    task automatic finish(input string tag);
        exp_t e;
        int cyc = 0;
        while (!bus.done && cyc < 4000) begin
            @(negedge clock);
            cyc++;
        end
        chk({tag, "_done"}, bus.done, 1);
        e = sb.pop_front();
        chk({tag, "_passes"}, 32'(bus.passes_used), 32'(e.passes));
        chk({tag, "_neg"}, bus.neg_cycle, e.neg);
        chk({tag, "_busy_low"}, bus.busy, 0);
        @(negedge clock);
        chk({tag, "_done_pulse"}, bus.done, 0);
        chk({tag, "_passes_held"}, 32'(bus.passes_used), 32'(e.passes));
        for (int i = 0; i < 8; i++) begin
            if (i < int'(e.nn)) chk($sformatf("%s_node%0d", tag, i), 32'(dm[i]), 32'(e.w[i]));
        end
    endtask

    task automatic load_fwd();
        em[0] = ed(0, 1, 8'd3);
        em[1] = ed(1, 2, 8'hFF);
        em[2] = ed(2, 3, 8'd2);
    endtask

    task automatic push_chain(input logic [8:0] passes);
        ex = '0;
        ex.passes = passes;
        ex.nn = 4;
        ex.w[0] = wd(0, 0, 0);
        ex.w[1] = wd(0, 3, 0);
        ex.w[2] = wd(0, 2, 1);
        ex.w[3] = wd(0, 4, 2);
        sb.push_back(ex);
    endtask

    initial begin
        int dcount;
        for (int i = 0; i < 16; i++) em[i] = '0;
        for (int i = 0; i < 256; i++) dm[i] = '0;
        reset = 1'b1;
        bus.start = 1'b0;
        bus.src_node = '0;
        bus.num_nodes = '0;
        bus.num_edges = '0;
        repeat (3) @(negedge clock);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_neg", bus.neg_cycle, 0);
        chk("rst_passes", 32'(bus.passes_used), 0);
        chk("rst_we", bus.dm_we, 0);
        chk("rst_em_addr", 32'(bus.em_addr), 0);
        chk("rst_raddr1", 32'(bus.dm_raddr1), 0);
        chk("rst_waddr", 32'(bus.dm_waddr), 0);
        reset = 1'b0;

        // chain in order: one improving pass
        load_fwd();
        push_chain(1);
        launch(0, 4, 3);
        finish("fwd");

        // reverse chain, aborted by reset mid-run
        em[0] = ed(2, 3, 8'd2);
        em[1] = ed(1, 2, 8'hFF);
        em[2] = ed(0, 1, 8'd3);
        launch(0, 4, 3);
        repeat (40) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_passes", 32'(bus.passes_used), 0);
        chk("mid_rst_we", bus.dm_we, 0);
        chk("mid_rst_em_addr", 32'(bus.em_addr), 0);
        reset = 1'b0;
        dcount = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (bus.done || bus.busy) dcount++;
        end
        chk("mid_rst_quiet", dcount, 0);

        // reverse chain run to completion: pass limit N-1
        push_chain(3);
        launch(0, 4, 3);
        finish("rev");

        // node 3 unreachable
        em[0] = ed(0, 1, 8'd1);
        em[1] = ed(1, 2, 8'd1);
        ex = '0; ex.passes = 1; ex.nn = 4;
        ex.w[0] = wd(0, 0, 0); ex.w[1] = wd(0, 1, 0); ex.w[2] = wd(0, 2, 1); ex.w[3] = wd(1, 0, 3);
        sb.push_back(ex);
        launch(0, 4, 2);
        finish("unreach");

        // positive saturation
        em[0] = ed(0, 1, 8'd100);
        em[1] = ed(1, 2, 8'd100);
        ex = '0; ex.passes = 1; ex.nn = 3;
        ex.w[0] = wd(0, 0, 0); ex.w[1] = wd(0, 8'd100, 0); ex.w[2] = wd(0, 8'h7F, 1);
        sb.push_back(ex);
        launch(0, 3, 2);
        finish("sat_pos");

        // negative saturation
        em[0] = ed(0, 1, 8'h9C);
        em[1] = ed(1, 2, 8'h9C);
        ex = '0; ex.passes = 1; ex.nn = 3;
        ex.w[0] = wd(0, 0, 0); ex.w[1] = wd(0, 8'h9C, 0); ex.w[2] = wd(0, 8'h80, 1);
        sb.push_back(ex);
        launch(0, 3, 2);
        finish("sat_neg");

        // negative cycle 1->2->1 reachable from 0
        em[0] = ed(0, 1, 8'd1);
        em[1] = ed(1, 2, 8'd1);
        em[2] = ed(2, 1, 8'hFD);
        ex = '0; ex.passes = 2; ex.nn = 3;
`ifdef NEG_CYCLE_DETECT_EN
        ex.neg = 1'b1;
`endif
        ex.w[0] = wd(0, 0, 0); ex.w[1] = wd(0, 8'hFD, 2); ex.w[2] = wd(0, 8'h00, 1);
        sb.push_back(ex);
        launch(0, 3, 3);
        finish("negcyc");

        // E == 0: init only, source 1
        ex = '0; ex.passes = 0; ex.nn = 4;
        ex.w[0] = wd(1, 0, 0); ex.w[1] = wd(0, 0, 1); ex.w[2] = wd(1, 0, 2); ex.w[3] = wd(1, 0, 3);
        sb.push_back(ex);
        launch(1, 4, 0);
        finish("no_edges");

        // source outside node range
        load_fwd();
        ex = '0; ex.passes = 0; ex.nn = 4;
        ex.w[0] = wd(1, 0, 0); ex.w[1] = wd(1, 0, 1); ex.w[2] = wd(1, 0, 2); ex.w[3] = wd(1, 0, 3);
        sb.push_back(ex);
        launch(5, 4, 3);
        finish("src_oor");

        // single node
        ex = '0; ex.passes = 0; ex.nn = 1;
        ex.w[0] = wd(0, 0, 0);
        sb.push_back(ex);
        launch(0, 1, 3);
        finish("one_node");

        // second start while busy is ignored
        push_chain(1);
        launch(0, 4, 3);
        repeat (5) @(negedge clock);
        bus.src_node = 2;
        bus.num_nodes = 2;
        bus.start = 1'b1;
        @(negedge clock);
        bus.start = 1'b0;
        finish("busy_start");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
